// File: rtl/hs_io_bridge.sv
`default_nettype none
// ============================================================================
// Module   : hs_io_bridge
// Brief    : Byte-wide processor I/O bridge. TX path takes bytes from the
//            processor over a 4-phase handshake and streams them to a device
//            over valid/ready. RX path buffers device bytes and presents the
//            head byte to the processor with a pending-data interrupt.
// Revision : 1.0 - initial release
// ============================================================================
module hs_io_bridge #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          g_clk,
    input  logic          g_clr,
    input  logic [7:0]    proc_bus_out,
    input  logic          proc_hs_out,
    output logic          proc_hs_in,
    output logic [7:0]    proc_bus_in,
    input  logic          proc_rx_pop,
    output logic          proc_ext_int,
    output logic [7:0]    dev_tx_data,
    output logic          dev_tx_valid,
    input  logic          dev_tx_ready,
    input  logic [7:0]    dev_rx_data,
    input  logic          dev_rx_valid,
    output logic          dev_rx_ready,
    output logic [AW:0]   tx_count,
    output logic [AW:0]   rx_count,
    output logic          rx_underflow
);

    // Handshake FSM encoding. SYNC waits for hs_out low after reset so a
    // request held through reset cannot produce a duplicate push.
    localparam logic [1:0] c_st_sync = 2'd0;
    localparam logic [1:0] c_st_idle = 2'd1;
    localparam logic [1:0] c_st_ack  = 2'd2;

    logic [7:0]  r_tx_mem [0:DEPTH-1];
    logic [7:0]  r_rx_mem [0:DEPTH-1];
    logic [AW:0] r_tx_wr;
    logic [AW:0] r_tx_rd;
    logic [AW:0] r_rx_wr;
    logic [AW:0] r_rx_rd;
    logic [1:0]  r_state;
    logic        r_hs_in;
    logic        r_rx_underflow;

    logic        w_tx_empty;
    logic        w_tx_full;
    logic        w_rx_empty;
    logic        w_rx_full;
    logic        w_tx_push;
    logic        w_tx_pop;
    logic        w_rx_push;
    logic        w_rx_pop;

    // Occupancy flags; fullness uses the pointer wrap bit.
    assign w_tx_empty = (r_tx_wr == r_tx_rd);
    assign w_tx_full  = (r_tx_wr[AW-1:0] == r_tx_rd[AW-1:0]) && (r_tx_wr[AW] != r_tx_rd[AW]);
    assign w_rx_empty = (r_rx_wr == r_rx_rd);
    assign w_rx_full  = (r_rx_wr[AW-1:0] == r_rx_rd[AW-1:0]) && (r_rx_wr[AW] != r_rx_rd[AW]);

    // Transfer qualifiers, all evaluated on the pre-edge state.
    assign w_tx_push = (r_state == c_st_idle) && proc_hs_out && !w_tx_full;
    assign w_tx_pop  = !w_tx_empty && dev_tx_ready;
    assign w_rx_push = dev_rx_valid && !w_rx_full;
    assign w_rx_pop  = proc_rx_pop && !w_rx_empty;

    assign proc_hs_in   = r_hs_in;
    assign dev_tx_valid = !w_tx_empty;
    assign dev_tx_data  = r_tx_mem[r_tx_rd[AW-1:0]];
    assign dev_rx_ready = !w_rx_full;
    assign proc_ext_int = !w_rx_empty;
    assign proc_bus_in  = w_rx_empty ? 8'h00 : r_rx_mem[r_rx_rd[AW-1:0]];
    assign tx_count     = r_tx_wr - r_tx_rd;
    assign rx_count     = r_rx_wr - r_rx_rd;
    assign rx_underflow = r_rx_underflow;

    // FIFO storage writes; contents are intentionally left unreset.
    always_ff @(posedge g_clk) begin
        if (w_tx_push) r_tx_mem[r_tx_wr[AW-1:0]] <= proc_bus_out;
        if (w_rx_push) r_rx_mem[r_rx_wr[AW-1:0]] <= dev_rx_data;
    end

    // FIFO pointers and the sticky underflow flag.
    always_ff @(posedge g_clk or negedge g_clr) begin
        if (!g_clr) begin
            r_tx_wr        <= '0;
            r_tx_rd        <= '0;
            r_rx_wr        <= '0;
            r_rx_rd        <= '0;
            r_rx_underflow <= 1'b0;
        end else begin
            if (w_tx_push) r_tx_wr <= r_tx_wr + 1'b1;
            if (w_tx_pop)  r_tx_rd <= r_tx_rd + 1'b1;
            if (w_rx_push) r_rx_wr <= r_rx_wr + 1'b1;
            if (w_rx_pop)  r_rx_rd <= r_rx_rd + 1'b1;
            if (proc_rx_pop && w_rx_empty) r_rx_underflow <= 1'b1;
        end
    end

    // Processor write handshake: one push per request, registered acknowledge.
    always_ff @(posedge g_clk or negedge g_clr) begin
        if (!g_clr) begin
            r_state <= c_st_sync;
            r_hs_in <= 1'b0;
        end else begin
            case (r_state)
                c_st_sync: begin
                    r_hs_in <= 1'b0;
                    if (!proc_hs_out) r_state <= c_st_idle;
                end
                c_st_idle: begin
                    if (w_tx_push) begin
                        r_state <= c_st_ack;
                        r_hs_in <= 1'b1;
                    end
                end
                c_st_ack: begin
                    if (!proc_hs_out) begin
                        r_state <= c_st_idle;
                        r_hs_in <= 1'b0;
                    end
                end
                default: begin
                    r_state <= c_st_sync;
                    r_hs_in <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hs_io_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_hs_io_bridge
// Brief    : Scoreboard bench for hs_io_bridge. Expected bytes are queued as
//            stimulus is driven; a negedge observer logs every byte the DUT
//            hands out, and each scenario task compares the two.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hs_io_bridge;

    logic       g_clk;
    logic       g_clr;
    logic [7:0] proc_bus_out;
    logic       proc_hs_out;
    logic       proc_hs_in;
    logic [7:0] proc_bus_in;
    logic       proc_rx_pop;
    logic       proc_ext_int;
    logic [7:0] dev_tx_data;
    logic       dev_tx_valid;
    logic       dev_tx_ready;
    logic [7:0] dev_rx_data;
    logic       dev_rx_valid;
    logic       dev_rx_ready;
    logic [2:0] tx_count;
    logic [2:0] rx_count;
    logic       rx_underflow;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] tx_q[$];
    logic [7:0] rx_q[$];
    logic [7:0] tx_obs[$];
    logic [7:0] rx_obs[$];

    hs_io_bridge #(.DEPTH(4), .AW(2)) dut (
        .g_clk        (g_clk),
        .g_clr        (g_clr),
        .proc_bus_out (proc_bus_out),
        .proc_hs_out  (proc_hs_out),
        .proc_hs_in   (proc_hs_in),
        .proc_bus_in  (proc_bus_in),
        .proc_rx_pop  (proc_rx_pop),
        .proc_ext_int (proc_ext_int),
        .dev_tx_data  (dev_tx_data),
        .dev_tx_valid (dev_tx_valid),
        .dev_tx_ready (dev_tx_ready),
        .dev_rx_data  (dev_rx_data),
        .dev_rx_valid (dev_rx_valid),
        .dev_rx_ready (dev_rx_ready),
        .tx_count     (tx_count),
        .rx_count     (rx_count),
        .rx_underflow (rx_underflow)
    );

    initial g_clk = 1'b0;
    always #5 g_clk = ~g_clk;

    // Inputs only change just after a rising edge, so the negedge view shows
    // exactly which transfers the next rising edge will perform.
    always @(negedge g_clk) begin
        if (g_clr) begin
            if (dev_tx_valid && dev_tx_ready) tx_obs.push_back(dev_tx_data);
            if (proc_rx_pop && proc_ext_int)  rx_obs.push_back(proc_bus_in);
        end
    end

    task automatic tick();
        @(posedge g_clk);
        #1;
    endtask

    // Full 4-phase write with bounded waits; ok=0 if either phase times out.
    task automatic proc_write(input logic [7:0] b, input int hold, output bit ok);
        int n;
        ok = 1'b1;
        proc_bus_out = b;
        proc_hs_out  = 1'b1;
        tx_q.push_back(b);
        n = 0;
        while (proc_hs_in !== 1'b1 && n < 20) begin tick(); n++; end
        if (proc_hs_in !== 1'b1) ok = 1'b0;
        repeat (hold) tick();
        proc_hs_out = 1'b0;
        n = 0;
        while (proc_hs_in !== 1'b0 && n < 20) begin tick(); n++; end
        if (proc_hs_in !== 1'b0) ok = 1'b0;
    endtask

    task automatic test_reset();
        g_clr = 1'b0; proc_hs_out = 1'b1; proc_bus_out = 8'h77;
        proc_rx_pop = 1'b0; dev_tx_ready = 1'b0; dev_rx_valid = 1'b0; dev_rx_data = 8'h00;
        tick(); tick();
        n_cmp++; if (proc_hs_in !== 1'b0) begin n_bad++; $display("FAIL rst_hs_in: got %b want 0", proc_hs_in); end
        n_cmp++; if (tx_count !== 3'd0 || rx_count !== 3'd0) begin n_bad++; $display("FAIL rst_counts: got tx=%0d rx=%0d want 0/0", tx_count, rx_count); end
        n_cmp++; if (dev_tx_valid !== 1'b0 || proc_ext_int !== 1'b0) begin n_bad++; $display("FAIL rst_valid_int: got %b/%b want 0/0", dev_tx_valid, proc_ext_int); end
        n_cmp++; if (dev_rx_ready !== 1'b1 || proc_bus_in !== 8'h00 || rx_underflow !== 1'b0) begin n_bad++; $display("FAIL rst_misc: got rdy=%b bus=%h uf=%b want 1/00/0", dev_rx_ready, proc_bus_in, rx_underflow); end
        g_clr = 1'b1;
        repeat (5) tick();
        n_cmp++; if (tx_count !== 3'd0 || proc_hs_in !== 1'b0) begin n_bad++; $display("FAIL sync_hold: got cnt=%0d hs_in=%b want 0/0", tx_count, proc_hs_in); end
        proc_hs_out = 1'b0;
        tick();
        proc_bus_out = 8'hA5; proc_hs_out = 1'b1;
        tx_q.push_back(8'hA5);
        n_cmp++; if (proc_hs_in !== 1'b0) begin n_bad++; $display("FAIL pre_push_hs_in: got %b want 0", proc_hs_in); end
        tick();
        n_cmp++; if (tx_count !== 3'd1 || proc_hs_in !== 1'b1) begin n_bad++; $display("FAIL a5_push: got cnt=%0d hs_in=%b want 1/1", tx_count, proc_hs_in); end
        proc_hs_out = 1'b0;
        tick();
        n_cmp++; if (proc_hs_in !== 1'b0) begin n_bad++; $display("FAIL a5_release: got %b want 0", proc_hs_in); end
        dev_tx_ready = 1'b1; tick(); dev_tx_ready = 1'b0;
        n_cmp++;
        if (tx_obs.size() != 1) begin n_bad++; $display("FAIL a5_drain_n: got %0d bytes want 1", tx_obs.size()); tx_obs.delete(); tx_q.delete(); end
        else if (tx_obs[0] !== tx_q[0]) begin n_bad++; $display("FAIL a5_drain: got %h want %h", tx_obs[0], tx_q[0]); end
        tx_obs.delete(); tx_q.delete();
    endtask

    task automatic test_tx_fill();
        bit ok;
        logic [7:0] got, exp;
        dev_tx_ready = 1'b0;
        for (int b = 1; b <= 4; b++) begin
            proc_write(8'(b), 0, ok);
            n_cmp++; if (!ok) begin n_bad++; $display("FAIL fill_ack_%0d: got timeout want ack", b); end
        end
        n_cmp++; if (tx_count !== 3'd4 || dev_tx_data !== 8'h01) begin n_bad++; $display("FAIL fill_count: got cnt=%0d head=%h want 4/01", tx_count, dev_tx_data); end
        proc_bus_out = 8'h05; proc_hs_out = 1'b1; tx_q.push_back(8'h05);
        repeat (3) tick();
        n_cmp++; if (proc_hs_in !== 1'b0 || tx_count !== 3'd4) begin n_bad++; $display("FAIL full_stall: got hs_in=%b cnt=%0d want 0/4", proc_hs_in, tx_count); end
        dev_tx_ready = 1'b1; tick(); dev_tx_ready = 1'b0;
        n_cmp++; if (tx_count !== 3'd3 || proc_hs_in !== 1'b0) begin n_bad++; $display("FAIL full_pop_nopush: got cnt=%0d hs_in=%b want 3/0", tx_count, proc_hs_in); end
        tick();
        n_cmp++; if (tx_count !== 3'd4 || proc_hs_in !== 1'b1) begin n_bad++; $display("FAIL late_push: got cnt=%0d hs_in=%b want 4/1", tx_count, proc_hs_in); end
        proc_hs_out = 1'b0; tick();
        dev_tx_ready = 1'b1; repeat (5) tick(); dev_tx_ready = 1'b0;
        n_cmp++; if (tx_obs.size() != 5) begin n_bad++; $display("FAIL fill_drain_n: got %0d bytes want 5", tx_obs.size()); end
        while (tx_q.size() > 0 && tx_obs.size() > 0) begin
            got = tx_obs.pop_front(); exp = tx_q.pop_front();
            n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL fill_order: got %h want %h", got, exp); end
        end
        tx_obs.delete(); tx_q.delete();
    endtask

    task automatic test_tx_order();
        bit ok;
        logic [7:0] got, exp;
        dev_tx_ready = 1'b1;
        proc_write(8'h10, 6, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL order_ack_10: got timeout want ack"); end
        proc_write(8'h20, 6, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL order_ack_20: got timeout want ack"); end
        proc_write(8'h30, 6, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL order_ack_30: got timeout want ack"); end
        repeat (2) tick();
        dev_tx_ready = 1'b0;
        n_cmp++; if (tx_obs.size() != 3) begin n_bad++; $display("FAIL order_n: got %0d bytes want 3", tx_obs.size()); end
        while (tx_q.size() > 0 && tx_obs.size() > 0) begin
            got = tx_obs.pop_front(); exp = tx_q.pop_front();
            n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL order_byte: got %h want %h", got, exp); end
        end
        n_cmp++; if (tx_count !== 3'd0) begin n_bad++; $display("FAIL order_empty: got %0d want 0", tx_count); end
        tx_obs.delete(); tx_q.delete();
    endtask

    task automatic test_rx();
        logic [7:0] got, exp;
        dev_rx_valid = 1'b1;
        dev_rx_data = 8'hC3; rx_q.push_back(8'hC3); tick();
        dev_rx_data = 8'h3C; rx_q.push_back(8'h3C); tick();
        dev_rx_valid = 1'b0;
        n_cmp++; if (proc_ext_int !== 1'b1 || proc_bus_in !== 8'hC3 || rx_count !== 3'd2) begin n_bad++; $display("FAIL rx_head: got int=%b bus=%h cnt=%0d want 1/c3/2", proc_ext_int, proc_bus_in, rx_count); end
        proc_rx_pop = 1'b1; tick(); proc_rx_pop = 1'b0;
        n_cmp++; if (proc_bus_in !== 8'h3C || proc_ext_int !== 1'b1) begin n_bad++; $display("FAIL rx_second: got bus=%h int=%b want 3c/1", proc_bus_in, proc_ext_int); end
        proc_rx_pop = 1'b1; tick(); proc_rx_pop = 1'b0;
        n_cmp++; if (proc_ext_int !== 1'b0 || proc_bus_in !== 8'h00) begin n_bad++; $display("FAIL rx_drained: got int=%b bus=%h want 0/00", proc_ext_int, proc_bus_in); end
        n_cmp++; if (rx_obs.size() != 2) begin n_bad++; $display("FAIL rx_n: got %0d bytes want 2", rx_obs.size()); end
        while (rx_q.size() > 0 && rx_obs.size() > 0) begin
            got = rx_obs.pop_front(); exp = rx_q.pop_front();
            n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL rx_byte: got %h want %h", got, exp); end
        end
        rx_obs.delete(); rx_q.delete();
    endtask

    task automatic test_rx_full();
        logic [7:0] got, exp;
        dev_rx_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            dev_rx_data = 8'h41 + 8'(i); rx_q.push_back(dev_rx_data); tick();
        end
        n_cmp++; if (dev_rx_ready !== 1'b0 || rx_count !== 3'd4) begin n_bad++; $display("FAIL rx_full: got rdy=%b cnt=%0d want 0/4", dev_rx_ready, rx_count); end
        dev_rx_data = 8'hEE; rx_q.push_back(8'hEE);
        proc_rx_pop = 1'b1; tick(); proc_rx_pop = 1'b0;
        n_cmp++; if (rx_count !== 3'd3 || dev_rx_ready !== 1'b1) begin n_bad++; $display("FAIL full_pop_blocked: got cnt=%0d rdy=%b want 3/1", rx_count, dev_rx_ready); end
        tick();
        dev_rx_valid = 1'b0;
        n_cmp++; if (rx_count !== 3'd4) begin n_bad++; $display("FAIL ee_accept: got cnt=%0d want 4", rx_count); end
        proc_rx_pop = 1'b1; repeat (4) tick(); proc_rx_pop = 1'b0;
        n_cmp++; if (proc_ext_int !== 1'b0 || rx_underflow !== 1'b0) begin n_bad++; $display("FAIL rx_full_drain: got int=%b uf=%b want 0/0", proc_ext_int, rx_underflow); end
        n_cmp++; if (rx_obs.size() != 5) begin n_bad++; $display("FAIL rx_full_n: got %0d bytes want 5", rx_obs.size()); end
        while (rx_q.size() > 0 && rx_obs.size() > 0) begin
            got = rx_obs.pop_front(); exp = rx_q.pop_front();
            n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL rx_full_byte: got %h want %h", got, exp); end
        end
        rx_obs.delete(); rx_q.delete();
    endtask

    task automatic test_underflow_reset();
        bit ok;
        int n;
        proc_rx_pop = 1'b1; tick(); proc_rx_pop = 1'b0;
        n_cmp++; if (rx_underflow !== 1'b1 || rx_count !== 3'd0) begin n_bad++; $display("FAIL underflow: got uf=%b cnt=%0d want 1/0", rx_underflow, rx_count); end
        dev_tx_ready = 1'b0;
        proc_write(8'h61, 0, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL mid_first_ack: got timeout want ack"); end
        proc_bus_out = 8'h62; proc_hs_out = 1'b1;
        n = 0;
        while (proc_hs_in !== 1'b1 && n < 20) begin tick(); n++; end
        n_cmp++; if (proc_hs_in !== 1'b1 || tx_count !== 3'd2) begin n_bad++; $display("FAIL mid_ack_state: got hs_in=%b cnt=%0d want 1/2", proc_hs_in, tx_count); end
        #1 g_clr = 1'b0;
        #1;
        n_cmp++; if (proc_hs_in !== 1'b0 || tx_count !== 3'd0 || rx_count !== 3'd0) begin n_bad++; $display("FAIL async_rst: got hs_in=%b tx=%0d rx=%0d want 0/0/0", proc_hs_in, tx_count, rx_count); end
        n_cmp++; if (rx_underflow !== 1'b0 || dev_tx_valid !== 1'b0) begin n_bad++; $display("FAIL async_rst_flags: got uf=%b valid=%b want 0/0", rx_underflow, dev_tx_valid); end
        tx_q.delete(); tx_obs.delete();
        proc_hs_out = 1'b0;
        tick();
        g_clr = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_tx_fill();
        test_tx_order();
        test_rx();
        test_rx_full();
        test_underflow_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hs_io_bridge.md
Name: hs_io_bridge

Overview:
Byte-wide I/O bridge that sits directly downstream of the processor's bus_out/hs_out output port and upstream of its bus_in/ext_int input port. TX path: accepts bytes from the processor over a 4-phase handshake, buffers them in a TX FIFO, and streams them to an external device over valid/ready. RX path: buffers device bytes in an RX FIFO, presents the head byte on the processor's bus_in, and raises ext_int while data is pending.

Parameters:
DEPTH, 4, entries per FIFO (power of two, >= 2)
AW, 2, log2(DEPTH), pointer width

Ports:
g_clk  in  1  clock; all state updates on rising edge
g_clr  in  1  asynchronous active-low reset
proc_bus_out  in  8  processor output byte (processor bus_out)
proc_hs_out  in  1  processor write request (processor hs_out)
proc_hs_in  out  1  write acknowledge to processor (processor hs_in)
proc_bus_in  out  8  RX FIFO head byte (processor bus_in)
proc_rx_pop  in  1  one-cycle strobe: processor has loaded proc_bus_in (RIN load)
proc_ext_int  out  1  RX data pending (processor ext_int)
dev_tx_data  out  8  TX FIFO head byte
dev_tx_valid  out  1  TX FIFO non-empty
dev_tx_ready  in  1  device accepts dev_tx_data this cycle
dev_rx_data  in  8  device byte
dev_rx_valid  in  1  device byte valid
dev_rx_ready  out  1  RX FIFO not full
tx_count  out  AW+1  TX occupancy, 0..DEPTH
rx_count  out  AW+1  RX occupancy, 0..DEPTH
rx_underflow  out  1  sticky: proc_rx_pop seen while RX empty

Behaviour:
- Reset (g_clr=0, async): both FIFOs empty (pointers 0, counts 0); proc_hs_in=0; rx_underflow=0; handshake FSM=SYNC. All outputs are then derived values: dev_tx_valid=0, proc_ext_int=0, dev_rx_ready=1, proc_bus_in=8'h00.
- FIFO storage: DEPTH x 8 registers; read/write pointers AW+1 bits wide, wrapping mod 2*DEPTH.
  - empty = pointers equal.
  - full = low bits equal and MSBs differ.
  - count = wr - rd (mod 2^(AW+1)).
  - Memory contents are not reset.
- Handshake FSM (TX write side), inputs sampled at rising edge:
  - SYNC: proc_hs_in=0. Move to IDLE when proc_hs_out=0. This prevents a request held high through reset from producing a duplicate push.
  - IDLE: proc_hs_in=0. If proc_hs_out=1 and TX not full: push proc_bus_out on this edge, go to ACK. If proc_hs_out=1 and TX full: stay in IDLE (processor stalls; no push, no ack).
  - ACK: proc_hs_in=1 (registered; asserts the cycle after the push edge). When proc_hs_out=0 is sampled, go to IDLE and deassert proc_hs_in. Exactly one push per request, regardless of how long hs_out stays high.
  - Latency: push edge -> hs_in high 1 cycle later. hs_out low sampled -> hs_in low after that edge. The next request is sampled no earlier than the following edge.
- TX read side: dev_tx_valid = !tx_empty; dev_tx_data = mem[rd] (combinational). A pop occurs on an edge where valid && dev_tx_ready.
- RX write side: dev_rx_ready = !rx_full. A push occurs on an edge where dev_rx_valid && dev_rx_ready. Valid while full is ignored; the device must hold its data.
- RX read side: proc_bus_in = mem[rd] when non-empty, else 8'h00. proc_ext_int = !rx_empty (level). proc_rx_pop while non-empty pops on that edge. proc_rx_pop while empty does not change state and sets rx_underflow (cleared only by reset).
- Simultaneous push and pop on the same FIFO:
  - Non-empty and non-full: both occur; count unchanged.
  - Full: pop occurs; push is blocked this cycle because fullness is evaluated on the pre-edge state. TX FSM stays in IDLE; RX ready is already 0.
  - Empty: push occurs, pop is ignored.
- Reset asserted mid-handshake or mid-transfer: immediate return to the reset values above. Buffered bytes are lost.

Test Plan:
- Reset with hs_out=1 held: after g_clr rises, hold hs_out=1 for 5 cycles -> no push, tx_count=0, hs_in=0. Drop then raise hs_out with 8'hA5 -> tx_count=1 and hs_in=1 one cycle after the push edge.
- TX fill/stall: dev_tx_ready=0, write 8'h01..8'h04 -> tx_count=4. A fifth request with 8'h05 -> hs_in stays 0. Pulse dev_tx_ready for 1 cycle -> dev_tx_data was 8'h01, then the 8'h05 push completes, hs_in=1, tx_count=4.
- TX ordering: write 8'h10,8'h20,8'h30 with dev_tx_ready=1 -> device observes 10,20,30 in order, each exactly once, even with hs_out held high for 6 cycles per request.
- RX path: device pushes 8'hC3,8'h3C -> ext_int=1, proc_bus_in=8'hC3. After one proc_rx_pop -> 8'h3C. After a second pop -> ext_int=0, proc_bus_in=8'h00.
- RX full plus simultaneous pop: fill RX with 4 bytes (dev_rx_ready=0), then hold dev_rx_valid=1 with 8'hEE and pulse pop -> pop occurs, 8'hEE not accepted that edge, accepted the next edge, rx_count=4.
- Underflow and mid-op reset: pop while RX empty -> rx_underflow=1, rx_count stays 0. Assert g_clr low in ACK state with tx_count=2 -> hs_in=0, counts=0, rx_underflow=0 immediately, without waiting for a clock edge.
